// File: rtl/ethernet_pkg.sv
// Shared Ethernet definitions for the MII transmit and receive framers.
package ethernet_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        PAD,
        FCS,
        IFG
    } tx_state_t;

    localparam logic [3:0]  PREAMBLE_NIBBLE  = 4'h5;
    localparam logic [3:0]  SFD_NIBBLE       = 4'hD;
    localparam logic [31:0] CRC_POLY         = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT         = 32'hFFFFFFFF;

    localparam int unsigned BYTE_CNT_W       = 11;
    localparam int unsigned PREAMBLE_NIBBLES = 16;
    localparam int unsigned FCS_NIBBLES      = 8;

endpackage

// File: rtl/ethernet_tx_crc32_byte.sv
// Combinational reflected CRC-32 update over one byte, LSB first.
import ethernet_pkg::*;

module crc32_byte (
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next_c
);

    always_comb begin
        crc_next_c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            crc_next_c = crc_next_c[0] ? ((crc_next_c >> 1) ^ CRC_POLY) : (crc_next_c >> 1);
        end
    end

endmodule

// File: rtl/ethernet_tx.sv
// MII transmit framer: preamble/SFD, payload, optional padding, CRC-32 FCS and
// inter-frame gap, driven from a byte valid/ready/last stream.
import ethernet_pkg::*;

module ethernet_tx #(
    parameter bit          PAD_EN      = 1'b1,
    parameter int unsigned MIN_BYTES   = 60,
    parameter int unsigned IFG_NIBBLES = 24
) (
    input  logic       eth_tx_clk,
    input  logic       rst,
    input  logic [7:0] tx_byte,
    input  logic       tx_byte_valid,
    input  logic       tx_byte_last,
    output logic       tx_byte_ready,
    output logic [3:0] eth_txd,
    output logic       eth_tx_en,
    output logic       eth_txerr,
    output logic       tx_underflow
);

    localparam int unsigned CNT_W = 16;
    localparam logic [BYTE_CNT_W-1:0] MIN_CNT = BYTE_CNT_W'(MIN_BYTES);
    // The IDLE cycle that follows IFG supplies the final gap nibble.
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'((IFG_NIBBLES > 1) ? (IFG_NIBBLES - 2) : 0);

    tx_state_t             state;
    logic [CNT_W-1:0]      nib_cnt;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [31:0]           crc;
    logic [7:0]            cur_byte;
    logic                  cur_last;
    logic                  half;

    logic [7:0]            crc_data_c;
    logic [31:0]           crc_next_c;
    logic [31:0]           fcs_c;
    logic [3:0]            fcs_nibble_c;
    logic [BYTE_CNT_W-1:0] byte_cnt_inc_c;

    assign crc_data_c     = (state == PAD) ? 8'h00 : tx_byte;
    assign fcs_c          = ~crc;
    assign fcs_nibble_c   = fcs_c[{nib_cnt[2:0], 2'b00} +: 4];
    assign byte_cnt_inc_c = (&byte_cnt) ? byte_cnt : byte_cnt + BYTE_CNT_W'(1);

    crc32_byte u_crc (
        .crc        (crc),
        .data       (crc_data_c),
        .crc_next_c (crc_next_c)
    );

    // Outputs are computed one edge ahead so every MII pin comes straight from a flop.
    always_ff @(posedge eth_tx_clk) begin
        if (rst) begin
            state         <= IDLE;
            nib_cnt       <= '0;
            byte_cnt      <= '0;
            crc           <= CRC_INIT;
            cur_byte      <= '0;
            cur_last      <= 1'b0;
            half          <= 1'b0;
            eth_txd       <= '0;
            eth_tx_en     <= 1'b0;
            eth_txerr     <= 1'b0;
            tx_byte_ready <= 1'b0;
            tx_underflow  <= 1'b0;
        end else begin
            eth_txerr     <= 1'b0;
            tx_underflow  <= 1'b0;
            tx_byte_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    eth_tx_en <= 1'b0;
                    eth_txd   <= '0;
                    nib_cnt   <= '0;
                    byte_cnt  <= '0;
                    crc       <= CRC_INIT;
                    half      <= 1'b0;
                    cur_last  <= 1'b0;
                    if (tx_byte_valid) begin
                        state <= PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    eth_tx_en <= 1'b1;
                    if (nib_cnt == CNT_W'(PREAMBLE_NIBBLES - 1)) begin
                        eth_txd       <= SFD_NIBBLE;
                        tx_byte_ready <= 1'b1;
                        half          <= 1'b0;
                        state         <= PAYLOAD;
                    end else begin
                        eth_txd <= PREAMBLE_NIBBLE;
                        nib_cnt <= nib_cnt + CNT_W'(1);
                    end
                end
                PAYLOAD: begin
                    eth_tx_en <= 1'b1;
                    if (!half) begin
                        // Ready was high last cycle; a missing byte aborts the frame.
                        if (tx_byte_valid) begin
                            cur_byte <= tx_byte;
                            cur_last <= tx_byte_last;
                            eth_txd  <= tx_byte[3:0];
                            crc      <= crc_next_c;
                            byte_cnt <= byte_cnt_inc_c;
                            half     <= 1'b1;
                        end else begin
                            eth_txd      <= '0;
                            eth_txerr    <= 1'b1;
                            tx_underflow <= 1'b1;
                            nib_cnt      <= '0;
                            state        <= IFG;
                        end
                    end else begin
                        eth_txd <= cur_byte[7:4];
                        half    <= 1'b0;
                        if (cur_last) begin
                            nib_cnt <= '0;
                            state   <= (PAD_EN && (byte_cnt < MIN_CNT)) ? PAD : FCS;
                        end else begin
                            tx_byte_ready <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    eth_tx_en <= 1'b1;
                    eth_txd   <= '0;
                    if (!half) begin
                        crc      <= crc_next_c;
                        byte_cnt <= byte_cnt_inc_c;
                        half     <= 1'b1;
                    end else begin
                        half <= 1'b0;
                        if (byte_cnt >= MIN_CNT) begin
                            nib_cnt <= '0;
                            state   <= FCS;
                        end
                    end
                end
                FCS: begin
                    eth_tx_en <= 1'b1;
                    eth_txd   <= fcs_nibble_c;
                    if (nib_cnt == CNT_W'(FCS_NIBBLES - 1)) begin
                        nib_cnt <= '0;
                        state   <= IFG;
                    end else begin
                        nib_cnt <= nib_cnt + CNT_W'(1);
                    end
                end
                IFG: begin
                    eth_tx_en <= 1'b0;
                    eth_txd   <= '0;
                    if (nib_cnt >= IFG_LAST) begin
                        state <= IDLE;
                    end else begin
                        nib_cnt <= nib_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ethernet_tx.sv
// Directed bench for ethernet_tx: one unpadded and one padded instance share a
// byte driver and a nibble monitor; expected values are hand-derived or from a bit-serial CRC.
module tb_ethernet_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic [7:0] tx_byte;
    logic       tx_byte_valid;
    logic       tx_byte_last;

    logic       rdy0, en0, err0, uf0;
    logic [3:0] txd0;
    logic       rdy1, en1, err1, uf1;
    logic [3:0] txd1;
    logic       rdy_m, en_m, err_m, uf_m;
    logic [3:0] txd_m;

    always #5 clk = ~clk;

    ethernet_tx #(.PAD_EN(1'b0), .MIN_BYTES(60), .IFG_NIBBLES(24)) dut0 (
        .eth_tx_clk    (clk),
        .rst           (rst),
        .tx_byte       (tx_byte),
        .tx_byte_valid (tx_byte_valid & ~sel),
        .tx_byte_last  (tx_byte_last),
        .tx_byte_ready (rdy0),
        .eth_txd       (txd0),
        .eth_tx_en     (en0),
        .eth_txerr     (err0),
        .tx_underflow  (uf0)
    );

    ethernet_tx #(.PAD_EN(1'b1), .MIN_BYTES(60), .IFG_NIBBLES(24)) dut1 (
        .eth_tx_clk    (clk),
        .rst           (rst),
        .tx_byte       (tx_byte),
        .tx_byte_valid (tx_byte_valid & sel),
        .tx_byte_last  (tx_byte_last),
        .tx_byte_ready (rdy1),
        .eth_txd       (txd1),
        .eth_tx_en     (en1),
        .eth_txerr     (err1),
        .tx_underflow  (uf1)
    );

    assign rdy_m = sel ? rdy1 : rdy0;
    assign en_m  = sel ? en1  : en0;
    assign err_m = sel ? err1 : err0;
    assign uf_m  = sel ? uf1  : uf0;
    assign txd_m = sel ? txd1 : txd0;

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor state, written only by the monitor process below.
    int          cyc;
    logic [4:0]  cap[$];
    int          runs[$];
    int          gaps[$];
    int          rise_cyc;
    int          err_cnt;
    int          uf_cnt;
    int          dbl_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bit en_prev  = 1'b0;
        bit rdy_prev = 1'b0;
        bit seen     = 1'b0;
        int run      = 0;
        int gap      = 0;
        forever begin
            @(negedge clk);
            if (en_m === 1'b1) begin
                cap.push_back({err_m, txd_m});
                if (!en_prev) begin
                    rise_cyc = cyc;
                    if (seen) gaps.push_back(gap);
                    run = 0;
                end
                run++;
                if (err_m === 1'b1) err_cnt++;
                en_prev = 1'b1;
            end else begin
                if (en_prev) begin
                    runs.push_back(run);
                    seen = 1'b1;
                    gap  = 0;
                end
                gap++;
                en_prev = 1'b0;
            end
            if (uf_m === 1'b1) uf_cnt++;
            if (rdy_m === 1'b1 && rdy_prev) dbl_cnt++;
            rdy_prev = (rdy_m === 1'b1);
        end
    end

    // Stimulus entries: {hole, last, byte}; a hole withholds valid through one ready.
    logic [9:0] stim[$];
    int         drv_start;
    int         drv_first_hs;

    task automatic drive();
        int         idx    = 0;
        int         budget = 0;
        bit         hs     = 1'b0;
        logic [9:0] e;
        drv_first_hs = -1;
        while (idx < stim.size() && budget < 5000) begin
            @(negedge clk);
            budget++;
            if (hs) idx++;
            hs = 1'b0;
            if (idx < stim.size()) begin
                e             = stim[idx];
                tx_byte_valid = ~e[9];
                tx_byte_last  = e[8];
                tx_byte       = e[7:0];
                if (budget == 1) drv_start = cyc;
                if (rdy_m === 1'b1) begin
                    hs = 1'b1;
                    if (drv_first_hs < 0) drv_first_hs = cyc;
                end
            end
        end
        tx_byte_valid = 1'b0;
        tx_byte_last  = 1'b0;
        if (idx < stim.size()) check("drv_timeout", 32'(idx), 32'(stim.size()));
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n     = 0;
        while (quiet < 30 && n < 3000) begin
            @(negedge clk);
            n++;
            quiet = (en_m === 1'b1) ? 0 : quiet + 1;
        end
        if (quiet < 30) check("idle_timeout", 32'(quiet), 32'd30);
    endtask

    function automatic logic [31:0] ref_fcs(input logic [7:0] b[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    function automatic logic [31:0] cap_word(input int idx);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) w[4*k +: 4] = cap[idx + k][3:0];
        return w;
    endfunction

    logic [3:0] fcs_exp [8] = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
    logic [7:0] ref_bytes[$];
    logic [7:0] spacing_bytes [6] = '{8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h81, 8'h7E};

    initial begin
        int s, r, g, u0, e0, d0, bad, n;
        rst           = 1'b1;
        sel           = 1'b0;
        tx_byte       = 8'h00;
        tx_byte_valid = 1'b0;
        tx_byte_last  = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_en",    32'(en_m),  32'd0);
        check("rst_txd",   32'(txd_m), 32'd0);
        check("rst_err",   32'(err_m), 32'd0);
        check("rst_ready", 32'(rdy_m), 32'd0);
        check("rst_uf",    32'(uf_m),  32'd0);
        check("rst_en1",   32'(en1),   32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic unpadded frame "123456789".
        s = cap.size(); r = runs.size();
        stim.delete();
        for (int i = 0; i < 9; i++) stim.push_back({1'b0, 1'(i == 8), 8'(8'h31 + i)});
        drive();
        wait_idle();
        check("lat_en",    32'(rise_cyc - drv_start),     32'd2);
        check("lat_ready", 32'(drv_first_hs - drv_start), 32'd17);
        check("basic_nibs", 32'(cap.size() - s), 32'd42);
        check("basic_run",  32'(runs[r]),        32'd42);
        for (int i = 0; i < 16; i++)
            check("basic_pre", 32'(cap[s + i]), (i == 15) ? 32'hD : 32'h5);
        for (int i = 0; i < 9; i++) begin
            check("basic_lo", 32'(cap[s + 16 + 2*i]),     32'(i + 1));
            check("basic_hi", 32'(cap[s + 17 + 2*i]),     32'h3);
        end
        for (int i = 0; i < 8; i++)
            check("basic_fcs", 32'(cap[s + 34 + i]), 32'(fcs_exp[i]));

        // Padded short frame E1 11 E5.
        sel = 1'b1;
        repeat (2) @(negedge clk);
        s = cap.size(); r = runs.size();
        stim = {10'h0E1, 10'h011, 10'h1E5};
        drive();
        wait_idle();
        check("pad_run",  32'(runs[r]),        32'd144);
        check("pad_nibs", 32'(cap.size() - s), 32'd144);
        check("pad_p0", 32'(cap[s + 16]), 32'h1);
        check("pad_p1", 32'(cap[s + 17]), 32'hE);
        check("pad_p4", 32'(cap[s + 20]), 32'h5);
        check("pad_p5", 32'(cap[s + 21]), 32'hE);
        bad = 0;
        for (int i = 0; i < 114; i++) if (cap[s + 22 + i] != 5'h00) bad++;
        check("pad_zero", 32'(bad), 32'd0);
        ref_bytes = {8'hE1, 8'h11, 8'hE5};
        for (int i = 0; i < 57; i++) ref_bytes.push_back(8'h00);
        check("pad_fcs", cap_word(s + 136), ref_fcs(ref_bytes));

        // Back-to-back frames with valid held high.
        sel = 1'b0;
        repeat (2) @(negedge clk);
        s = cap.size(); r = runs.size(); g = gaps.size();
        stim = {10'h0A5, 10'h13C, 10'h10F};
        drive();
        wait_idle();
        check("b2b_run_a", 32'(runs[r]),     32'd28);
        check("b2b_run_b", 32'(runs[r + 1]), 32'd26);
        check("b2b_gap",   32'(gaps[g + 1]), 32'd24);
        ref_bytes = {8'hA5, 8'h3C};
        check("b2b_fcs_a", cap_word(s + 20), ref_fcs(ref_bytes));
        ref_bytes = {8'h0F};
        check("b2b_fcs_b", cap_word(s + 46), ref_fcs(ref_bytes));
        check("b2b_pre_b", 32'(cap[s + 28]), 32'h5);

        // Underflow on the third fetch, then a follow-on frame.
        s = cap.size(); r = runs.size(); g = gaps.size();
        u0 = uf_cnt; e0 = err_cnt;
        stim = {10'h011, 10'h022, 10'h200, 10'h177};
        drive();
        wait_idle();
        check("uf_pulse",  32'(uf_cnt - u0),  32'd1);
        check("uf_err",    32'(err_cnt - e0), 32'd1);
        check("uf_run",    32'(runs[r]),      32'd21);
        check("uf_b1",     32'(cap[s + 16]),  32'h1);
        check("uf_b2",     32'(cap[s + 19]),  32'h2);
        check("uf_errnib", 32'(cap[s + 20]),  32'h10);
        check("uf_gap",    32'(gaps[g + 1]),  32'd24);
        check("uf_next",   32'(runs[r + 1]),  32'd26);
        ref_bytes = {8'h77};
        check("uf_next_fcs", cap_word(s + 21 + 18), ref_fcs(ref_bytes));

        // Reset in the middle of the payload.
        @(negedge clk);
        tx_byte = 8'h11; tx_byte_last = 1'b0; tx_byte_valid = 1'b1;
        n = 0;
        while (rdy_m !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("mid_ready_timeout", 32'(n), 32'd0);
        repeat (3) @(negedge clk);
        check("mid_pre_en", 32'(en_m), 32'd1);
        rst = 1'b1; tx_byte_valid = 1'b0;
        @(negedge clk);
        check("mid_en",    32'(en_m),  32'd0);
        check("mid_ready", 32'(rdy_m), 32'd0);
        check("mid_txd",   32'(txd_m), 32'd0);
        rst = 1'b0;
        s = cap.size(); r = runs.size();
        stim = {10'h15A};
        drive();
        wait_idle();
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (cap[s + i] != ((i == 15) ? 5'h0D : 5'h05)) bad++;
        check("mid_new_pre", 32'(bad), 32'd0);
        check("mid_new_run", 32'(runs[r]), 32'd26);
        ref_bytes = {8'h5A};
        check("mid_new_fcs", cap_word(s + 18), ref_fcs(ref_bytes));

        // Random stall before a frame; ready spacing and byte integrity.
        sel = 1'b1;
        repeat ($urandom_range(9, 2)) @(negedge clk);
        s = cap.size(); r = runs.size(); d0 = dbl_cnt;
        stim.delete();
        for (int i = 0; i < 6; i++) stim.push_back({1'b0, 1'(i == 5), spacing_bytes[i]});
        drive();
        wait_idle();
        check("sp_dbl", 32'(dbl_cnt - d0), 32'd0);
        check("sp_run", 32'(runs[r]),      32'd144);
        for (int i = 0; i < 6; i++)
            check("sp_byte", 32'({cap[s + 17 + 2*i][3:0], cap[s + 16 + 2*i][3:0]}),
                  32'(spacing_bytes[i]));
        check("all_dbl", 32'(dbl_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ethernet_tx.md
# ethernet_tx

MII transmit framer, the transmit-side counterpart of `ethernet_rx`. It accepts a byte stream from the MAC/user logic through a valid/ready/last handshake and drives a 4-bit MII transmit interface. Framing per frame: it prepends preamble and SFD, pads short frames, appends a computed CRC-32 FCS, and enforces the inter-frame gap. It runs entirely in the PHY-supplied `eth_tx_clk` domain.

## Interface
Parameters:
- `PAD_EN`, 1: pad frames shorter than `MIN_BYTES` with 0x00 before the FCS.
- `MIN_BYTES`, 60: minimum frame length in bytes, excluding the FCS.
- `IFG_NIBBLES`, 24: idle cycles after each frame (12 bytes).

Ports:
- `eth_tx_clk`, in, 1: MII transmit clock, the only clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `tx_byte`, in, 8: payload byte.
- `tx_byte_valid`, in, 1: `tx_byte` is valid.
- `tx_byte_last`, in, 1: the current byte is the final payload byte of the frame.
- `tx_byte_ready`, out, 1: the byte is consumed on any cycle where both valid and ready are high.
- `eth_txd`, out, 4: MII transmit nibble, low nibble of each byte first.
- `eth_tx_en`, out, 1: MII transmit enable.
- `eth_txerr`, out, 1: MII transmit error, used only on abort.
- `tx_underflow`, out, 1: one-cycle pulse when a frame is aborted.

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, PAD, FCS, IFG. All outputs are registered.
- **IDLE:** `eth_tx_en`=0 and `eth_txd`=0. If `tx_byte_valid`=1, go to PREAMBLE. The byte is not consumed in this state.
- **PREAMBLE:** 16 nibble cycles: fifteen 0x5, then 0xD. This is seven 0x55 bytes followed by SFD 0xD5.
  - `tx_byte_ready` is high during the cycle that drives 0xD.
- **PAYLOAD:** each byte takes two cycles, low nibble then high nibble.
  - `tx_byte_ready` is high only in the cycle that drives the high nibble of the current byte. This fetches the next byte.
  - If the current byte was `last`, ready stays low and the next state is PAD, or FCS if no padding is needed.
- **Underflow:** ready=1 while valid=0 in PAYLOAD or PREAMBLE.
  - The next cycle drives `eth_tx_en`=1 and `eth_txerr`=1 with `eth_txd`=0 for one cycle, and pulses `tx_underflow`.
  - The state then goes to IFG. No FCS is sent.
- **PAD:** entered only when `PAD_EN`=1 and the byte count is below `MIN_BYTES`. It sends 0x00 bytes until the count equals `MIN_BYTES`.
- **Byte counter:** 11 bits, saturating at 2047. It counts payload and pad bytes.
- **CRC-32 (IEEE 802.3):**
  - Reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, updated once per payload/pad byte.
  - FCS = ~crc, sent as 4 bytes LSB byte first, each byte low nibble first.
- **FCS:** 8 nibble cycles.
- **IFG:** `IFG_NIBBLES` cycles with `eth_tx_en`=0, then IDLE. Input is ignored and ready is low.
- **Simultaneous events:** if `last` and valid are both high on a fetch, the byte is sent and the frame then ends normally.

## Timing
- **Reset values:** `eth_txd`=0, `eth_tx_en`=0, `eth_txerr`=0, `tx_byte_ready`=0, `tx_underflow`=0, state IDLE, CRC=0xFFFFFFFF, counters=0.
- **Reset mid-frame:** outputs go to their reset values on the next edge. No IFG and no FCS are sent. The next frame may start immediately.
- **Start latency:** with valid seen in IDLE at edge N, `eth_tx_en`=1 and `eth_txd`=0x5 from edge N+1.
  - Ready is high in cycle N+16.
  - The first payload low nibble is driven in cycle N+17.
- **Frame length:** `eth_tx_en` is high for 16 + 2·max(L, MIN_BYTES·PAD_EN) + 8 contiguous cycles, with no gaps.
- **Back-to-back frames:** the earliest next `eth_tx_en` comes `IFG_NIBBLES`+1 cycles after the last FCS nibble.
- **Handshake limits:** `tx_byte_ready` is never high on two consecutive cycles. Byte throughput is at most one per two clocks.

## Structure
- **Package `ethernet_pkg`:**
  - State enum `tx_state_t`.
  - Constants `PREAMBLE_NIBBLE`=4'h5, `SFD_NIBBLE`=4'hD, `CRC_POLY`=32'hEDB88320, `CRC_INIT`=32'hFFFFFFFF.
  - Shared with `ethernet_rx`.
- **Sub-module `crc32_byte`:** combinational next-CRC from (crc, byte). It is reused by the receive-side FCS checker.

## Test plan
- **Basic frame:** reset, then a frame "123456789" with `PAD_EN`=0.
  - `eth_txd` shows 15×0x5 then 0xD.
  - Payload nibbles follow as 1,3,2,3,…,9,3.
  - FCS nibbles are 6,2,9,3,4,F,B,C (CRC 0xCBF43926).
  - `eth_tx_en` is high for exactly 42 cycles.
- **Padding:** payload E1 11 E5 (last on E5) with `PAD_EN`=1.
  - 57 zero bytes of padding follow.
  - `eth_tx_en` is high for 16+120+8=144 cycles.
  - The FCS matches a reference CRC over 60 bytes.
- **Back-to-back frames:** two frames with valid held high.
  - Exactly 24 cycles of `eth_tx_en`=0 between them.
  - The second preamble starts on the 25th cycle.
- **Underflow:** drop valid on the third byte fetch.
  - One cycle with `eth_tx_en`=1, `eth_txerr`=1.
  - `tx_underflow` pulses once.
  - No FCS; the IFG follows.
- **Reset mid-frame:** assert `rst` during PAYLOAD.
  - Next cycle: `eth_tx_en`=0 and ready=0.
  - A new frame issued immediately after produces a correct full preamble.
- **Ready spacing:** random valid stalls before the frame.
  - Ready is never high on consecutive cycles.
  - No payload byte is duplicated or dropped.
